// File: rtl/tcdm_initiator_pkg.sv
// tcdm_initiator_pkg: shared FSM state encoding and counter-width helper for tcdm_initiator.
package tcdm_initiator_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  // Width able to hold 0..max_outstanding inclusive.
  function automatic int outstanding_w(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction
endpackage

// File: rtl/tcdm_initiator_rfifo.sv
// tcdm_initiator_rfifo: read-response FIFO, registered storage, synchronous clear.
// Ports: push_i/data_i write side, pop_i/valid_o/data_o read side, count_o fill level.
module tcdm_initiator_rfifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [DW-1:0]              data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [DW-1:0]              data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wptr_q] = data_i;
    wptr_d = clear_i ? '0 : wptr_q + PW'(push_i);
    rptr_d = clear_i ? '0 : rptr_q + PW'(pop_i);
    cnt_d  = clear_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  assign valid_o = cnt_q != '0;
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/tcdm_initiator.sv
// tcdm_initiator: TCDM master issuing a strided sequence of word reads or writes.
// Ports: start_i/cfg_* job setup, busy_o/done_o/err_o status, wdata_* write stream in,
// rdata_* read stream out, tcdm_* master port towards the responder.
module tcdm_initiator
  import tcdm_initiator_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            start_i,
  input  logic [AW-1:0]   cfg_base_i,
  input  logic [AW-1:0]   cfg_stride_i,
  input  logic [15:0]     cfg_len_i,
  input  logic            cfg_write_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  input  logic            wdata_valid_i,
  output logic            wdata_ready_o,
  input  logic [DW-1:0]   wdata_i,
  output logic            rdata_valid_o,
  input  logic            rdata_ready_i,
  output logic [DW-1:0]   rdata_o,
  output logic            tcdm_req_o,
  output logic [AW-1:0]   tcdm_add_o,
  output logic            tcdm_wen_o,
  output logic [DW/8-1:0] tcdm_be_o,
  output logic [DW-1:0]   tcdm_data_o,
  input  logic            tcdm_gnt_i,
  input  logic            tcdm_r_valid_i,
  input  logic [DW-1:0]   tcdm_r_data_i
);
  localparam int OW = outstanding_w(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [15:0]   len_q, len_d, idx_q, idx_d;
  logic          write_q, write_d, pend_q, pend_d, err_q, err_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [CW-1:0] fcnt;
  logic          credit, gnt, rsp_ok, push, pop, fifo_empty_nxt;
  // Read credit also counts FIFO occupancy so every in-flight response has a slot.
  assign credit = write_q ? (int'(outst_q) < MAX_OUTSTANDING) && wdata_valid_i
                          : (int'(outst_q) + int'(fcnt) < MAX_OUTSTANDING);
  // A pending request keeps req high without re-evaluating credit.
  assign tcdm_req_o     = (state_q == ISSUE) && (pend_q || credit);
  assign gnt            = tcdm_req_o && tcdm_gnt_i;
  assign rsp_ok         = tcdm_r_valid_i && (outst_q != '0);
  assign push           = rsp_ok && !write_q;
  assign pop            = rdata_valid_o && rdata_ready_i;
  assign fifo_empty_nxt = (int'(fcnt) + int'(push) - int'(pop)) == 0;
  always_comb begin
    state_d  = state_q;
    addr_d   = gnt ? addr_q + stride_q : addr_q;
    idx_d    = gnt ? idx_q + 16'd1 : idx_q;
    stride_d = stride_q;
    len_d    = len_q;
    write_d  = write_q;
    pend_d   = tcdm_req_o && !tcdm_gnt_i;
    outst_d  = outst_q + OW'(gnt) - OW'(rsp_ok);
    err_d    = err_q || (tcdm_r_valid_i && outst_q == '0);
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d  = (cfg_len_i == 16'd0) ? DONE : ISSUE;
        addr_d   = cfg_base_i;
        stride_d = cfg_stride_i;
        len_d    = cfg_len_i;
        write_d  = cfg_write_i;
        idx_d    = '0;
        outst_d  = '0;
        err_d    = 1'b0;
      end
      ISSUE: if (gnt && idx_q == len_q - 16'd1) state_d = DRAIN;
      // Look at next-cycle occupancy so DONE follows the final pop directly.
      DRAIN: if (outst_d == '0 && fifo_empty_nxt) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      outst_d = '0;
      pend_d  = 1'b0;
      err_d   = 1'b0;
      idx_d   = '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      outst_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      outst_q  <= outst_d;
    end
  end
  tcdm_initiator_rfifo #(.DEPTH(MAX_OUTSTANDING), .DW(DW)) u_rfifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (tcdm_r_data_i),
    .pop_i   (pop),
    .valid_o (rdata_valid_o),
    .data_o  (rdata_o),
    .count_o (fcnt)
  );
  assign busy_o        = (state_q == ISSUE) || (state_q == DRAIN);
  assign done_o        = state_q == DONE;
  assign err_o         = err_q;
  assign wdata_ready_o = gnt && write_q;
  assign tcdm_add_o    = addr_q;
  assign tcdm_wen_o    = tcdm_req_o && !write_q;
  assign tcdm_be_o     = {(DW/8){tcdm_req_o}};
  assign tcdm_data_o   = (tcdm_req_o && write_q) ? wdata_i : '0;
endmodule

// File: doc/tcdm_initiator.md
# tcdm_initiator

Synthesizable TCDM master that issues a programmed sequence of word reads or writes into a TCDM responder: dummy data memory, stack memory or a cluster TCDM port. It is the initiator counterpart to the bench memory models. It streams write data in and read data out over valid/ready, tracks outstanding transactions against a credit limit, and pulses `done_o` once every response has been consumed. It is used to preload, scrub or read back result regions independently of the core.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width (one TCDM word).
- `MAX_OUTSTANDING`, 4: max granted-but-unanswered requests; also read FIFO depth; power of two, ≥2.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `clear_i` in 1: synchronous soft reset of all state.
- `start_i` in 1: launch job; sampled only in IDLE.
- `cfg_base_i` in AW: first byte address.
- `cfg_stride_i` in AW: byte increment per word.
- `cfg_len_i` in 16: number of words.
- `cfg_write_i` in 1: 1 = write job, 0 = read job.
- `busy_o` out 1: job in progress.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: sticky; set by unexpected `tcdm_r_valid_i`.
- `wdata_valid_i` in 1, `wdata_ready_o` out 1, `wdata_i` in DW: write-data stream.
- `rdata_valid_o` out 1, `rdata_ready_i` in 1, `rdata_o` out DW: read-data stream.
- `tcdm_req_o` out 1, `tcdm_add_o` out AW, `tcdm_wen_o` out 1 (1 = read), `tcdm_be_o` out DW/8, `tcdm_data_o` out DW, `tcdm_gnt_i` in 1, `tcdm_r_valid_i` in 1, `tcdm_r_data_i` in DW: TCDM master port.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on `start_i` with `cfg_len_i` ≠ 0.
  - Latch all cfg, clear the issue index and both counters.
- IDLE → DONE on `start_i` with `cfg_len_i` = 0. No TCDM traffic is generated.
- ISSUE: `tcdm_req_o` rises only when a credit is available.
  - Read credit: `outstanding + fifo_count < MAX_OUTSTANDING`.
  - Write credit: `outstanding < MAX_OUTSTANDING` and `wdata_valid_i`.
  - Once raised, `req`, `add`, `wen`, `data` and `be` hold stable until `tcdm_gnt_i`. Credits are never re-evaluated while a request is pending.
- Address for word k: `cfg_base_i + k*cfg_stride_i`, truncated to AW bits (wrap-around permitted).
- `tcdm_be_o` is all ones. `tcdm_data_o` = `wdata_i` for writes, 0 for reads.
- `wdata_ready_o` = `tcdm_req_o & tcdm_gnt_i & cfg_write`: the write word is consumed on its grant.
- Each grant increments `outstanding`; each `tcdm_r_valid_i` decrements it. Same-cycle grant and response leaves it unchanged.
- Every granted request, write included, gets exactly one `r_valid`.
  - Write responses are discarded.
  - Read responses are pushed into the read FIFO. Overflow is impossible by the credit rule.
- ISSUE → DRAIN on the grant of word `cfg_len-1`.
- DRAIN → DONE when `outstanding == 0` and the FIFO is empty.
- DONE → IDLE unconditionally. `done_o` = 1 in DONE only.
- `tcdm_r_valid_i` with `outstanding == 0` sets `err_o`.
  - The response is ignored and the counter does not underflow.
  - `err_o` is cleared only by reset, `clear_i` or an accepted `start_i`.
- `clear_i` forces IDLE and empties FIFO and counters in the same edge. Abandoning a pending request is the caller's responsibility.
- `start_i` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0 (`busy_o`, `done_o`, `err_o`, `tcdm_req_o`, `tcdm_add_o`, `tcdm_wen_o`, `tcdm_be_o`, `tcdm_data_o`, `wdata_ready_o`, `rdata_valid_o`, `rdata_o`). State is IDLE.
- `start_i` accepted at edge T: `busy_o` and the first `tcdm_req_o` are high from cycle T+1.
- Read FIFO: registered output. Data pushed on `r_valid` at cycle t appears on `rdata_o` at t+1.
- Zero-wait responder (gnt always 1, r_valid one cycle after grant) and `rdata_ready_i` = 1:
  - Sustained throughput is one word per cycle.
  - For len = N: grants in cycles T+1..T+N, last response at T+N+1, last rdata at T+N+2.
  - `done_o` at T+N+3; `busy_o` falls in the same cycle as `done_o` rises.
- Write job, same conditions: `done_o` at T+N+2.
- Zero-length start: `done_o` at T+1, `busy_o` stays 0.
- `rdata_valid_o` holds with stable data until `rdata_ready_i`.

## Structure
- `tcdm_initiator_pkg`: FSM state enum and the `OUTSTANDING_W = $clog2(MAX_OUTSTANDING+1)` helper function.
- Sub-module `tcdm_initiator_rfifo`: synchronous FIFO, depth `MAX_OUTSTANDING`, width DW, registered output, with `clear_i`. The top level holds the FSM, address generator and credit logic.

## Test plan
- Read N=8, base 0x1C010000, stride 4, zero-wait memory preloaded with k → addresses 0x1C010000..0x1C01001C, `rdata_o` 0..7 in order, `done_o` at T+11.
- Write N=4, stride 8, wdata 0xA0..0xA3 with random gaps in `wdata_valid_i` → memory at base+0/8/16/24 holds 0xA0..0xA3, `done_o` once, `err_o` = 0.
- Random `gnt` stall (50%), `rdata_ready_i` low for 10 cycles, read N=16 → never more than 4 granted-unanswered, `req`/`add` stable while un-granted, no data lost or reordered.
- Base 0xFFFFFFF8, stride 4, N=4 read → addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- `cfg_len_i` = 0 start → `done_o` at T+1, no `tcdm_req_o`. Spurious `r_valid` in IDLE → `err_o` = 1, counter stays 0.
- `clear_i` mid-read after 3 grants → next cycle IDLE, `busy_o` = 0, FIFO empty. A subsequent N=2 job completes normally.
